alfa_cod: RTL and testbench
===========================

ALFA_COD -- requirements
Module: alfa_cod

Interface
REQ-001 Parameter DEB_CICLOS, default 4, debounce length in cycles (legal 1..255).
REQ-002 Parameter REP_CICLOS, default 16, auto-repeat period in cycles (legal 1..255; used only when ALFA_COD_REPETE_EN is defined).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 teclas  input  8  note keys, active-high; bit i selects note code i.
REQ-006 tom_in  input  1  tone-select switch.
REQ-007 pronto  input  1  consumer ready.
REQ-008 valido  output  1  code available.
REQ-009 Tom  output  1  latched tone bit; feeds the display decoder's Tom input.
REQ-010 notas1, notas2, notas3  output  1 each  latched note code; notas1 is the MSB.

Function
REQ-011 teclas and tom_in SHALL each pass through a two-flop synchronizer before any other use.
REQ-012 Candidate code SHALL be {tom_s, idx}, where idx is the lowest set bit index of the synchronized keys; no key set means no candidate.
REQ-013 FSM states SHALL be OCIOSO, ESTAVEL, ENVIA and SOLTAR.
- OCIOSO -> ESTAVEL when a candidate exists; the candidate is stored and the 8-bit counter is loaded to 1.
REQ-014 ESTAVEL behaviour:
- candidate equal to stored code: counter increments;
- candidate differs: stored code is replaced and the counter reloads to 1;
- no candidate: return to OCIOSO;
- counter == DEB_CICLOS with equal candidate: load Tom/notas from stored code, go to ENVIA.
REQ-015 valido SHALL be 1 exactly while in ENVIA.
- Tom and notas1..3 are held constant while valido=1.
- Input changes in ENVIA are ignored.
REQ-016 A transfer SHALL occur on a cycle with valido=1 and pronto=1; the next state is SOLTAR and the counter clears.
REQ-017 pronto while valido=0 SHALL have no effect; there is no timeout in ENVIA.
REQ-018 SOLTAR SHALL return to OCIOSO after DEB_CICLOS consecutive cycles with no candidate; any candidate clears the release count.
REQ-019 Tom/notas1..3 SHALL keep the last transferred code outside ENVIA.
REQ-020 Latency: a key pattern stable from clock edge k SHALL give valido=1 after edge k+2+DEB_CICLOS.
REQ-021 Multiple keys pressed SHALL be resolved by the priority rule in REQ-012; a change in priority winner or in tom_s counts as a changed candidate.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously enter OCIOSO and clear synchronizers, counters, valido, Tom and notas1..3 to 0.
REQ-023 Reset asserted mid-handshake SHALL drop valido immediately; the pending code is discarded and not re-sent.
REQ-024 After rst_n deasserts, held keys SHALL be treated as a new press, debounced normally.

Configuration
REQ-025 Macro ALFA_COD_REPETE_EN SHALL control auto-repeat.
- Defined: in SOLTAR, if the candidate equals the last transferred code for REP_CICLOS consecutive cycles, go to ENVIA and re-send the same code.
- A differing candidate in SOLTAR restarts the repeat count.
REQ-026 Without ALFA_COD_REPETE_EN, exactly one transfer SHALL occur per press; REP_CICLOS is unused and no repeat logic is synthesized.

Verification (DEB_CICLOS=4, REP_CICLOS=16)
REQ-027 Reset, then teclas=8'h04, tom_in=1, pronto=1 -> valido=1 for 1 cycle at edge 6; Tom=1, notas=010; no further valido while held (macro off).
REQ-028 teclas=8'h81, tom_in=0, pronto=0 -> valido=1 held, notas=000; change keys to 8'h10 -> outputs unchanged; pronto=1 -> valido=0 next cycle.
REQ-029 Key bounce: 8'h20 for 2 cycles, 0 for 1 cycle, 8'h20 stable -> single transfer, notas=101, valido at edge 6 after final stable edge.
REQ-030 rst_n pulsed low while valido=1 -> valido, Tom, notas=0 asynchronously; key still held after release -> new transfer after 6 cycles.
REQ-031 Macro on, teclas=8'h08 held, pronto=1 -> transfers at edge 6 then every 17 cycles, each notas=011.
REQ-032 Release-then-repress the same key inside 4 cycles (macro off) -> no second transfer; release for 4 or more cycles then repress -> second transfer.

Source files
------------

// File: rtl/alfa_cod_if.sv
// Handshake bundle for alfa_cod: keys and tone switch in, latched note code and valido out.
// The master side drives keys/pronto; the slave side is the encoder.
interface alfa_cod_if;
   logic [7:0] teclas;
   logic       tom_in;
   logic       pronto;
   logic       valido;
   logic       Tom;
   logic       notas1;
   logic       notas2;
   logic       notas3;

   modport master (
      output teclas, tom_in, pronto,
      input  valido, Tom, notas1, notas2, notas3
   );

   modport slave (
      input  teclas, tom_in, pronto,
      output valido, Tom, notas1, notas2, notas3
   );
endinterface

// File: rtl/alfa_cod.sv
// Debounced priority note-key encoder with a valido/pronto handshake.
// Define ALFA_COD_REPETE_EN to enable auto-repeat of a held key while in SOLTAR.
module alfa_cod #(
   parameter int unsigned DEB_CICLOS = 4,
   parameter int unsigned REP_CICLOS = 16
) (
   input logic       clk,
   input logic       rst_n,
   alfa_cod_if.slave bus
);

   localparam logic [1:0] OCIOSO  = 2'd0;
   localparam logic [1:0] ESTAVEL = 2'd1;
   localparam logic [1:0] ENVIA   = 2'd2;
   localparam logic [1:0] SOLTAR  = 2'd3;

   localparam logic [7:0] DEB_LIM = 8'(DEB_CICLOS);
   localparam logic [7:0] DEB_M1  = 8'(DEB_CICLOS - 1);

   if (DEB_CICLOS == 0 || DEB_CICLOS > 255 || REP_CICLOS == 0 || REP_CICLOS > 255) begin : g_paramInvalido
      $error("alfa_cod: DEB_CICLOS and REP_CICLOS must lie in 1..255");
   end

   logic [7:0] r_tecS1;
   logic [7:0] r_tecS2;
   logic       r_tomS1;
   logic       r_tomS2;
   logic [1:0] r_state;
   logic [7:0] r_cnt;
   logic [3:0] r_code;
   logic [3:0] r_out;

   logic       w_temCand;
   logic [2:0] w_idx;
   logic [3:0] w_cand;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tecS1 <= 8'd0;
         r_tecS2 <= 8'd0;
         r_tomS1 <= 1'b0;
         r_tomS2 <= 1'b0;
      end else begin
         r_tecS1 <= bus.teclas;
         r_tecS2 <= r_tecS1;
         r_tomS1 <= bus.tom_in;
         r_tomS2 <= r_tomS1;
      end
   end

   // Lowest-numbered pressed key wins; scanning downward lets the lowest index overwrite.
   always_comb begin
      w_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_tecS2[i]) w_idx = 3'(i);
      end
   end

   assign w_temCand = |r_tecS2;
   assign w_cand    = {r_tomS2, w_idx};

`ifdef ALFA_COD_REPETE_EN
   localparam logic [7:0] REP_M1 = 8'(REP_CICLOS - 1);
   logic [7:0] r_repCnt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= OCIOSO;
         r_cnt    <= 8'd0;
         r_code   <= 4'd0;
         r_out    <= 4'd0;
`ifdef ALFA_COD_REPETE_EN
         r_repCnt <= 8'd0;
`endif
      end else begin
         case (r_state)
            OCIOSO: begin
               if (w_temCand) begin
                  r_code  <= w_cand;
                  r_cnt   <= 8'd1;
                  r_state <= ESTAVEL;
               end
            end
            ESTAVEL: begin
               if (!w_temCand) begin
                  r_state <= OCIOSO;
               end else if (w_cand != r_code) begin
                  r_code <= w_cand;
                  r_cnt  <= 8'd1;
               end else if (r_cnt == DEB_LIM) begin
                  r_out   <= r_code;
                  r_state <= ENVIA;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ENVIA: begin
               if (bus.pronto) begin
                  r_state  <= SOLTAR;
                  r_cnt    <= 8'd0;
`ifdef ALFA_COD_REPETE_EN
                  r_repCnt <= 8'd0;
`endif
               end
            end
            SOLTAR: begin
               // r_cnt here counts consecutive key-free cycles before re-arming.
               if (w_temCand) begin
                  r_cnt <= 8'd0;
               end else if (r_cnt == DEB_M1) begin
                  r_state <= OCIOSO;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
`ifdef ALFA_COD_REPETE_EN
               if (w_temCand && (w_cand == r_out)) begin
                  if (r_repCnt == REP_M1) begin
                     r_state <= ENVIA;
                  end else begin
                     r_repCnt <= r_repCnt + 8'd1;
                  end
               end else begin
                  r_repCnt <= 8'd0;
               end
`endif
            end
            default: r_state <= OCIOSO;
         endcase
      end
   end

   assign bus.valido = (r_state == ENVIA);
   assign bus.Tom    = r_out[3];
   assign bus.notas1 = r_out[2];
   assign bus.notas2 = r_out[1];
   assign bus.notas3 = r_out[0];

endmodule

// File: tb/tb_alfa_cod.sv
// Self-checking bench for alfa_cod: directed scenarios plus random key traffic, compared
// every cycle against a run-length reference model (ALFA_COD_REPETE_EN selects repeat checks).
module tb_alfa_cod;

   localparam int DEB = 4;
   localparam int REP = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   alfa_cod_if bus ();

   alfa_cod #(
      .DEB_CICLOS(DEB),
      .REP_CICLOS(REP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int edgeNo = 0;
   int dutXfers = 0;

   // Reference model: raw samples delayed two edges, then run-length rules on the candidate.
   logic [8:0] pipe [2];
   bit         mSending;
   bit         mLocked;
   int         runLen;
   int         quietLen;
   int         repLen;
   int         lastCand;
   logic [3:0] mOut;
   int         mXfers = 0;

   function automatic int candOf(input logic [8:0] s);
      for (int i = 0; i < 8; i++) begin
         if (s[i]) return (s[8] ? 8 : 0) + i;
      end
      return -1;
   endfunction

   task automatic modelReset();
      pipe[0]  = '0;
      pipe[1]  = '0;
      mSending = 1'b0;
      mLocked  = 1'b0;
      runLen   = 0;
      quietLen = 0;
      repLen   = 0;
      lastCand = -1;
      mOut     = 4'd0;
   endtask

   task automatic modelStep();
      int c;
      c = candOf(pipe[1]);
      if (mSending) begin
         if (bus.pronto) begin
            mSending = 1'b0;
            mLocked  = 1'b1;
            quietLen = 0;
            repLen   = 0;
            mXfers++;
         end
      end else if (mLocked) begin
         if (c < 0) begin
            quietLen++;
            repLen = 0;
            if (quietLen == DEB) begin
               mLocked = 1'b0;
               runLen  = 0;
            end
         end else begin
            quietLen = 0;
`ifdef ALFA_COD_REPETE_EN
            if (c == int'(mOut)) begin
               repLen++;
               if (repLen == REP) begin
                  mSending = 1'b1;
                  mLocked  = 1'b0;
               end
            end else begin
               repLen = 0;
            end
`endif
         end
      end else begin
         if (c < 0) begin
            runLen = 0;
         end else begin
            runLen   = (runLen > 0 && c == lastCand) ? runLen + 1 : 1;
            lastCand = c;
            if (runLen == DEB + 1) begin
               mSending = 1'b1;
               mOut     = 4'(c);
               runLen   = 0;
            end
         end
      end
      pipe[1] = pipe[0];
      pipe[0] = {bus.tom_in, bus.teclas};
   endtask

   task automatic checkOutput(input string tag);
      logic [4:0] obs;
      logic [4:0] exp;
      obs = {bus.valido, bus.Tom, bus.notas1, bus.notas2, bus.notas3};
      exp = {mSending, mOut};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, edgeNo, obs, exp);
      end
   endtask

   task automatic checkValue(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit pend;
      pend = (bus.valido === 1'b1) && (bus.pronto === 1'b1);
      @(posedge clk);
      if (pend) dutXfers++;
      if (rst_n) modelStep();
      edgeNo++;
      #1;
      checkOutput("ciclo");
   endtask

   task automatic applyStimulus(input logic [7:0] tec, input logic tom, input logic pr, input int n);
      bus.teclas = tec;
      bus.tom_in = tom;
      bus.pronto = pr;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic measureFirst(input int maxTicks, output int first);
      first = -1;
      for (int i = 0; i < maxTicks; i++) begin
         tick();
         if (first < 0 && bus.valido === 1'b1) first = i;
      end
   endtask

   function automatic int codeNow();
      return int'({bus.Tom, bus.notas1, bus.notas2, bus.notas3});
   endfunction

   initial begin
      int first;
      int x0;
      int len;
      logic [7:0] k;

      bus.teclas = 8'h00;
      bus.tom_in = 1'b0;
      bus.pronto = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset");
      rst_n = 1'b1;

      // Single key, tone on, consumer always ready.
      x0 = dutXfers;
      bus.teclas = 8'h04;
      bus.tom_in = 1'b1;
      bus.pronto = 1'b1;
      measureFirst(20, first);
      checkValue("latencia027", first, 2 + DEB);
      checkValue("codigo027", codeNow(), 4'b1010);
      applyStimulus(8'h04, 1'b1, 1'b1, 14);
`ifdef ALFA_COD_REPETE_EN
      checkValue("xfers027", dutXfers - x0, mXfers);
`else
      checkValue("xfers027", dutXfers - x0, 1);
`endif
      applyStimulus(8'h00, 1'b0, 1'b0, 8);

      // Two keys, no ready: valido holds, key changes ignored, then accepted.
      applyStimulus(8'h81, 1'b0, 1'b0, 12);
      checkValue("valido028", int'(bus.valido), 1);
      checkValue("codigo028", codeNow(), 0);
      applyStimulus(8'h10, 1'b0, 1'b0, 5);
      checkValue("ignora028", codeNow(), 0);
      applyStimulus(8'h10, 1'b0, 1'b1, 1);
      checkValue("aceite028", int'(bus.valido), 0);
      applyStimulus(8'h00, 1'b0, 1'b0, 8);

      // Bouncing key settles into one transfer.
      x0 = dutXfers;
      applyStimulus(8'h20, 1'b0, 1'b1, 2);
      applyStimulus(8'h00, 1'b0, 1'b1, 1);
      bus.teclas = 8'h20;
      measureFirst(12, first);
      checkValue("latencia029", first, 2 + DEB);
      checkValue("xfers029", dutXfers - x0, 1);
      checkValue("codigo029", codeNow(), 4'b0101);
      applyStimulus(8'h00, 1'b0, 1'b0, 8);

      // Reset in the middle of a pending handshake.
      x0 = dutXfers;
      applyStimulus(8'h02, 1'b1, 1'b0, 8);
      checkValue("pendente030", int'(bus.valido), 1);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("rstAsync030");
      tick();
      rst_n = 1'b1;
      measureFirst(10, first);
      checkValue("latencia030", first, 2 + DEB);
      applyStimulus(8'h02, 1'b1, 1'b1, 1);
      checkValue("xfers030", dutXfers - x0, 1);
      checkValue("codigo030", codeNow(), 4'b1001);
      applyStimulus(8'h00, 1'b0, 1'b0, 8);

      // Short release does not re-arm; a release of DEB cycles does.
      x0 = dutXfers;
      applyStimulus(8'h40, 1'b0, 1'b1, 10);
      applyStimulus(8'h00, 1'b0, 1'b1, 2);
      applyStimulus(8'h40, 1'b0, 1'b1, 10);
      checkValue("curta032", dutXfers - x0, 1);
      applyStimulus(8'h00, 1'b0, 1'b1, DEB);
      applyStimulus(8'h40, 1'b0, 1'b1, 12);
      checkValue("longa032", dutXfers - x0, 2);
      applyStimulus(8'h00, 1'b0, 1'b0, 8);

`ifdef ALFA_COD_REPETE_EN
      begin
         int vEdges[$];
         logic prevV;
         prevV = 1'b0;
         bus.teclas = 8'h08;
         bus.tom_in = 1'b0;
         bus.pronto = 1'b1;
         for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.valido === 1'b1 && !prevV) vEdges.push_back(i);
            prevV = bus.valido;
         end
         checkValue("repeticoes031", vEdges.size(), 4);
         for (int j = 0; j < vEdges.size() && j < 4; j++) begin
            checkValue("borda031", vEdges[j], 2 + DEB + j * (REP + 1));
         end
         checkValue("codigo031", codeNow(), 4'b0011);
         applyStimulus(8'h00, 1'b0, 1'b0, 8);
      end
`endif

      // Random key traffic against the model.
      for (int s = 0; s < 60; s++) begin
         case ($urandom_range(0, 3))
            0:       k = 8'h00;
            1, 2:    k = 8'(1 << $urandom_range(0, 7));
            default: k = 8'($urandom);
         endcase
         bus.teclas = k;
         bus.tom_in = 1'($urandom);
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            bus.pronto = ($urandom_range(0, 2) == 0);
            tick();
         end
      end
      applyStimulus(8'h00, 1'b0, 1'b1, 10);
      checkValue("xfersTotal", dutXfers, mXfers);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
